// File: rtl/rng_arb_pkg.sv
// rng_arb_pkg: FSM encoding and shared constants for the RNG SOP arbiter
package rng_arb_pkg;
    localparam int SOP_W = 128;
    localparam int TIMEOUT_DEF = 1024;
    typedef enum logic [1:0] {IDLE, WAIT, DELIVER} state_t;
endpackage

// File: rtl/rng_sop_arb_if.sv
// rng_sop_arb_if: requester handshake plus RNG SOP word signals of the arbiter
interface rng_sop_arb_if #(parameter int NUM_REQ = 4);
    import rng_arb_pkg::*;
    logic [NUM_REQ-1:0] req, ack, err;
    logic [SOP_W-1:0] ack_data, sop_data;
    logic sop_valid, rng_sw_reset, rd_sop, arb_busy;
    modport master (output req, sop_valid, sop_data, rng_sw_reset, input ack, ack_data, err, rd_sop, arb_busy);
    modport slave (input req, sop_valid, sop_data, rng_sw_reset, output ack, ack_data, err, rd_sop, arb_busy);
endinterface

// File: rtl/rng_rr_sel.sv
// rng_rr_sel: combinational round-robin pick of the first request after the last served index
module rng_rr_sel #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      grant,
    output logic               any_req
);
    always_comb begin
        grant = last;
        for (int i = NUM_REQ; i >= 1; i--)
            if (req[(int'(last) + i) % NUM_REQ]) grant = IW'((int'(last) + i) % NUM_REQ);
    end
    assign any_req = |req;
endmodule

// File: rtl/rng_sop_arb.sv
// rng_sop_arb: round-robin arbiter handing RNG SOP words to one requester at a time
module rng_sop_arb
    import rng_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic           rng_clk,
    input logic           rst,
    rng_sop_arb_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    state_t state;
    logic [IW-1:0] owner, last, gnt;
    logic any;
    logic [15:0] cnt;
    logic [SOP_W-1:0] cap;
    logic [NUM_REQ-1:0] own_oh;
    assign own_oh = NUM_REQ'(1) << owner;
    assign bus.arb_busy = state != IDLE;
    rng_rr_sel #(.NUM_REQ(NUM_REQ)) u_sel (.req(bus.req), .last(last), .grant(gnt), .any_req(any));
    always_ff @(posedge rng_clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            last <= IW'(NUM_REQ - 1);
            cnt <= '0;
            cap <= '0;
            bus.ack <= '0;
            bus.err <= '0;
            bus.rd_sop <= 1'b0;
            bus.ack_data <= '0;
        end else begin
            bus.ack <= '0;
            bus.err <= '0;
            bus.rd_sop <= 1'b0;
            bus.ack_data <= '0;
            if (bus.rng_sw_reset) begin
                state <= IDLE;
                cap <= '0;
                bus.err <= state != IDLE ? own_oh : '0;
            end else begin
                case (state)
                    IDLE: if (any) begin
                        owner <= gnt;
                        cnt <= '0;
                        state <= WAIT;
                    end
                    // a withdrawn request beats a word arriving in the same cycle
                    WAIT: if (!bus.req[owner]) state <= IDLE;
                    else if (bus.sop_valid) begin
                        bus.rd_sop <= 1'b1;
                        cap <= bus.sop_data;
                        state <= DELIVER;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        bus.err <= own_oh;
                        state <= IDLE;
                    end else cnt <= cnt + 16'd1;
                    DELIVER: begin
                        bus.ack <= own_oh;
                        bus.ack_data <= cap;
                        last <= owner;
                        cap <= '0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rng_sop_arb.sv
// tb_rng_sop_arb: scenario tasks with a scoreboard of expected ack/err events
module tb_rng_sop_arb;
    typedef struct packed {logic [3:0] ack; logic [3:0] err; logic [127:0] data;} ev_t;
    logic clk = 0, rst = 1, rd_prev = 0;
    int checks = 0, errors = 0, rd_cnt = 0, viol = 0;
    ev_t sb[$];

    rng_sop_arb_if #(.NUM_REQ(4)) bus();
    rng_sop_arb #(.NUM_REQ(4), .TIMEOUT(16)) dut (.rng_clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // protocol watch: one-hot ack/err across both vectors, no back-to-back pops
    always @(posedge clk) begin
        #1;
        if ($countones({bus.ack, bus.err}) > 1 || (bus.rd_sop && rd_prev)) viol++;
        if (bus.rd_sop) rd_cnt++;
        rd_prev = bus.rd_sop;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [127:0] data_of(input int k);
        return {4{32'hC0DE_0000 + 32'(k)}};
    endfunction

    task automatic push(input logic [3:0] a, input logic [3:0] r, input logic [127:0] d);
        ev_t e;
        e.ack = a; e.err = r; e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_ev(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.ack | bus.err) == 4'b0 && n < budget);
    endtask

    task automatic do_reset();
        bus.req = 0; bus.sop_valid = 0; bus.sop_data = 0; bus.rng_sw_reset = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
        checks++; if (bus.err !== 4'b0) begin errors++; $display("FAIL reset_err got %b want 0000", bus.err); end
        checks++; if (bus.rd_sop !== 1'b0) begin errors++; $display("FAIL reset_rd_sop got %b want 0", bus.rd_sop); end
        checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.arb_busy); end
        checks++; if (bus.ack_data !== 128'b0) begin errors++; $display("FAIL reset_data got %h want 0", bus.ack_data); end
    endtask

    task automatic test_single();
        ev_t e;
        bus.req = 4'b0001; bus.sop_valid = 1; bus.sop_data = {16{8'hA5}};
        push(4'b0001, 4'b0, {16{8'hA5}});
        @(negedge clk);
        checks++; if (bus.arb_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.arb_busy); end
        checks++; if (bus.rd_sop !== 1'b0) begin errors++; $display("FAIL single_rd_early got %b want 0", bus.rd_sop); end
        @(negedge clk);
        checks++; if (bus.rd_sop !== 1'b1) begin errors++; $display("FAIL single_rd got %b want 1", bus.rd_sop); end
        checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL single_ack_early got %b want 0000", bus.ack); end
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (bus.ack !== e.ack) begin errors++; $display("FAIL single_ack got %b want %b", bus.ack, e.ack); end
        checks++; if (bus.ack_data !== e.data) begin errors++; $display("FAIL single_data got %h want %h", bus.ack_data, e.data); end
        bus.req = 0; bus.sop_valid = 0;
        @(negedge clk);
        checks++; if (bus.ack_data !== 128'b0) begin errors++; $display("FAIL single_data_after got %h want 0", bus.ack_data); end
        checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", bus.arb_busy); end
    endtask

    task automatic test_back_to_back();
        ev_t e;
        int n, rd0;
        do_reset();
        rd0 = rd_cnt;
        bus.req = 4'b1111; bus.sop_valid = 1; bus.sop_data = data_of(0);
        for (int k = 0; k < 5; k++) push(4'b0001 << (k % 4), 4'b0, data_of(k));
        for (int k = 0; k < 5; k++) begin
            wait_ev(10, n);
            e = sb.pop_front();
            checks++; if (n !== 3) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 3", k, n); end
            checks++; if (bus.ack !== e.ack) begin errors++; $display("FAIL b2b_ack[%0d] got %b want %b", k, bus.ack, e.ack); end
            checks++; if (bus.ack_data !== e.data) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", k, bus.ack_data, e.data); end
            bus.sop_data = data_of(k + 1);
        end
        bus.req = 0; bus.sop_valid = 0;
        @(negedge clk);
        checks++; if (rd_cnt - rd0 !== 5) begin errors++; $display("FAIL b2b_pops got %0d want 5", rd_cnt - rd0); end
        checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", bus.arb_busy); end
    endtask

    task automatic test_timeout();
        ev_t e;
        int n, rd0;
        rd0 = rd_cnt;
        bus.req = 4'b0100; bus.sop_valid = 0;
        push(4'b0, 4'b0100, 128'b0);
        wait_ev(40, n);
        e = sb.pop_front();
        checks++; if (n !== 17) begin errors++; $display("FAIL timeout_cycles got %0d want 17", n); end
        checks++; if (bus.err !== e.err) begin errors++; $display("FAIL timeout_err got %b want %b", bus.err, e.err); end
        checks++; if (bus.ack !== e.ack) begin errors++; $display("FAIL timeout_ack got %b want %b", bus.ack, e.ack); end
        checks++; if (rd_cnt !== rd0) begin errors++; $display("FAIL timeout_pops got %0d want %0d", rd_cnt, rd0); end
        bus.req = 0;
        @(negedge clk);
        checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got %b want 0", bus.arb_busy); end
    endtask

    task automatic test_abort();
        int n, rd0;
        rd0 = rd_cnt;
        bus.req = 4'b0010;
        @(negedge clk);
        checks++; if (bus.arb_busy !== 1'b1) begin errors++; $display("FAIL abort_wait got %b want 1", bus.arb_busy); end
        bus.req = 0; bus.sop_valid = 1; bus.sop_data = data_of(99);
        @(negedge clk);
        checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.arb_busy); end
        wait_ev(6, n);
        checks++; if ((bus.ack | bus.err) !== 4'b0) begin errors++; $display("FAIL abort_event got ack %b err %b want none", bus.ack, bus.err); end
        checks++; if (rd_cnt !== rd0) begin errors++; $display("FAIL abort_pops got %0d want %0d", rd_cnt, rd0); end
        bus.sop_valid = 0;
    endtask

    task automatic test_sw_reset();
        ev_t e;
        int n;
        bus.req = 4'b0010; bus.sop_valid = 1; bus.sop_data = data_of(7);
        repeat (2) @(negedge clk);
        checks++; if (bus.rd_sop !== 1'b1) begin errors++; $display("FAIL swr_deliver got %b want 1", bus.rd_sop); end
        bus.rng_sw_reset = 1;
        @(negedge clk);
        checks++; if (bus.err !== 4'b0010) begin errors++; $display("FAIL swr_err got %b want 0010", bus.err); end
        checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL swr_ack got %b want 0000", bus.ack); end
        checks++; if (bus.ack_data !== 128'b0) begin errors++; $display("FAIL swr_data got %h want 0", bus.ack_data); end
        bus.req = 4'b0011;
        @(negedge clk);
        checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL swr_no_grant got %b want 0", bus.arb_busy); end
        bus.rng_sw_reset = 0; bus.sop_data = data_of(8);
        push(4'b0010, 4'b0, data_of(8));
        wait_ev(10, n);
        e = sb.pop_front();
        checks++; if (bus.ack !== e.ack) begin errors++; $display("FAIL swr_last_kept got %b want %b", bus.ack, e.ack); end
        checks++; if (bus.ack_data !== e.data) begin errors++; $display("FAIL swr_next_data got %h want %h", bus.ack_data, e.data); end
        bus.req = 0; bus.sop_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        ev_t e;
        int n;
        bus.req = 4'b0100; bus.sop_valid = 0;
        repeat (2) @(negedge clk);
        checks++; if (bus.arb_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_wait got %b want 1", bus.arb_busy); end
        rst = 1;
        @(negedge clk);
        checks++; if ({bus.ack, bus.err, bus.rd_sop, bus.arb_busy} !== 10'b0) begin errors++; $display("FAIL rst_mid_outs got %b want 0", {bus.ack, bus.err, bus.rd_sop, bus.arb_busy}); end
        checks++; if (bus.ack_data !== 128'b0) begin errors++; $display("FAIL rst_mid_data got %h want 0", bus.ack_data); end
        rst = 0; bus.req = 4'b1111; bus.sop_valid = 1; bus.sop_data = data_of(42);
        push(4'b0001, 4'b0, data_of(42));
        wait_ev(10, n);
        e = sb.pop_front();
        checks++; if (bus.ack !== e.ack) begin errors++; $display("FAIL rst_mid_first got %b want %b", bus.ack, e.ack); end
        checks++; if (bus.ack_data !== e.data) begin errors++; $display("FAIL rst_mid_data2 got %h want %h", bus.ack_data, e.data); end
        bus.req = 0; bus.sop_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_protocol();
        checks++; if (viol !== 0) begin errors++; $display("FAIL protocol_viol got %0d want 0", viol); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_abort();
        test_sw_reset();
        test_rst_mid();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rng_sop_arb.md
RNG_SOP_ARB -- requirements
Module: rng_sop_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the RNG SOP output (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum WAIT cycles before a request fails (2..65535); the counter is 16 bits.
REQ-003 SHALL have port rng_clk, input, 1 bit: the single clock. The block has one clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, NUM_REQ bits: level request per requester; the requester holds it until ack or err.
REQ-006 SHALL have port ack, output, NUM_REQ bits: one-cycle delivery pulse to the winner.
REQ-007 SHALL have port ack_data, output, 128 bits: random word, valid only while ack is high.
REQ-008 SHALL have port err, output, NUM_REQ bits: one-cycle failure pulse (timeout or SW reset).
REQ-009 SHALL have port sop_valid, input, 1 bit: RNG SOP word available.
REQ-010 SHALL have port sop_data, input, 128 bits: RNG SOP word.
REQ-011 SHALL have port rng_sw_reset, input, 1 bit: RNG software reset in progress.
REQ-012 SHALL have port rd_sop, output, 1 bit: one-cycle pop of the SOP word.
REQ-013 SHALL have port arb_busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and DELIVER.
REQ-015 IDLE: if any req bit is set, SHALL select the winner round-robin, starting at the index after the last served index, latch that index as owner, clear the timeout counter and go to WAIT in the next cycle.
REQ-016 WAIT: if sop_valid and req[owner] are both high, SHALL pulse rd_sop for one cycle, capture sop_data into an internal register in that same cycle, and go to DELIVER.
REQ-017 DELIVER: SHALL pulse ack[owner] for one cycle with ack_data equal to the captured word, update the last served index to owner, clear the captured register, and go to IDLE.
REQ-018 Latency: grant registered in cycle N, with sop_valid already high, SHALL produce rd_sop in N+1 and ack in N+2.
REQ-019 ack_data SHALL be all-zero in every cycle in which ack is low; no random word is ever visible outside its ack cycle.
REQ-020 In WAIT the counter SHALL increment each cycle without sop_valid; on reaching TIMEOUT-1 the block SHALL pulse err[owner] and go to IDLE with no rd_sop.
REQ-021 If req[owner] drops in WAIT, the block SHALL go to IDLE with no rd_sop, ack or err; if the drop coincides with sop_valid, the abort takes priority.
REQ-022 rng_sw_reset high SHALL, from any state, force IDLE, clear the captured word, pulse err[owner] if the state was WAIT or DELIVER, and suppress rd_sop and ack in that cycle.
REQ-023 While rng_sw_reset is high, IDLE SHALL grant nothing.
REQ-024 At most one bit of ack/err SHALL be high per cycle; rd_sop SHALL never be high for two consecutive cycles.
REQ-025 The last served index SHALL be updated only on ack (not on err or abort), and SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-026 On rst, the block SHALL be in IDLE, with ack, err, rd_sop and arb_busy = 0, ack_data and captured register = 0, timeout counter = 0, and last served index = NUM_REQ-1, so that requester 0 has first priority.
REQ-027 rst asserted mid-transaction SHALL abort it without an err pulse.

Structure
REQ-028 A shared package rng_arb_pkg SHALL hold the FSM state encoding, the 128-bit SOP width constant and the TIMEOUT default.
REQ-029 The round-robin priority selector SHALL be a sub-module rng_rr_sel: inputs req and last index, outputs grant index and any_req; purely combinational.

Verification
REQ-030 Scenario: req=4'b0001, sop_valid=1, sop_data=128'hA5..A5 -> rd_sop 1 cycle after grant, ack=4'b0001 with ack_data=A5..A5 one cycle later, ack_data=0 on the following cycle.
REQ-031 Scenario: req=4'b1111 held, sop_valid=1 -> ack order 0,1,2,3,0 with 3 cycles per grant.
REQ-032 Scenario: TIMEOUT=16, req=4'b0100, sop_valid=0 -> err=4'b0100 exactly 16 cycles after grant, rd_sop never high, then IDLE.
REQ-033 Scenario: req[1] drops in the same cycle sop_valid rises -> no rd_sop, no ack, no err, arb_busy=0 next cycle.
REQ-034 Scenario: rng_sw_reset pulses while in DELIVER -> err[owner]=1, ack=0, ack_data=0, last served index unchanged.
REQ-035 Scenario: rst mid-WAIT -> all outputs 0 next cycle; the next grant goes to requester 0.
